// File: rtl/weight_access_arbiter.sv
// weight_access_arbiter
//   Shares a single weight memory among three clients. The memory has one read
//   port, one write port and a one-cycle read latency. The clients are:
//     - inference fetch : read only, has priority on the read port
//     - STDP learning   : serialized read-modify-write with a saturating add
//     - host loader     : write only, yields to the learning write-back
//   Read data goes back to inference only when inference issued the read.
//   Host writes that target the address of an RMW in flight are held off.
//
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   inf_req/inf_addr                  inference read request
//   inf_gnt                           inference read issued this cycle
//   inf_rdata/inf_rvalid              inference read data, one cycle after inf_gnt
//   lrn_req/lrn_addr/lrn_delta        RMW request, held high until lrn_done
//   lrn_done                          one-cycle pulse when the RMW write is issued
//   host_wr_en/host_addr/host_data    host write request
//   host_ready                        host write issued this cycle
//   mem_read_*                        memory read port
//   mem_write_*                       memory write port
//   stat_inf_cnt/stat_lrn_cnt/stat_stall_cnt  statistics counters
//
// Build option
//   WARB_STATS_EN : when defined, stat_* are 32-bit wrapping event counters;
//                   otherwise they are tied to zero and no counter logic exists.
//
// Learning FSM
//   state  | meaning
//   IDLE   | no RMW in flight; accepts lrn_req and captures address/delta
//   RD     | waiting to win the read port for the RMW read
//   WAIT   | read issued; on read data, register the saturated sum
//   WR     | issue the write-back, pulse lrn_done

module weight_access_arbiter #(
  parameter int NUM_WEIGHTS  = 4096,
  parameter int WEIGHT_WIDTH = 9,
  parameter int ADDR_WIDTH   = $clog2(NUM_WEIGHTS),
  parameter int DELTA_WIDTH  = 8,
  parameter int MAX_STALL    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inf_req,
  input  logic [ADDR_WIDTH-1:0]   inf_addr,
  output logic                    inf_gnt,
  output logic [WEIGHT_WIDTH-1:0] inf_rdata,
  output logic                    inf_rvalid,
  input  logic                    lrn_req,
  input  logic [ADDR_WIDTH-1:0]   lrn_addr,
  input  logic [DELTA_WIDTH-1:0]  lrn_delta,
  output logic                    lrn_done,
  input  logic                    host_wr_en,
  input  logic [ADDR_WIDTH-1:0]   host_addr,
  input  logic [WEIGHT_WIDTH-1:0] host_data,
  output logic                    host_ready,
  output logic                    mem_read_en,
  output logic [ADDR_WIDTH-1:0]   mem_read_addr,
  input  logic [WEIGHT_WIDTH-1:0] mem_read_data,
  input  logic                    mem_read_valid,
  output logic                    mem_write_en,
  output logic [ADDR_WIDTH-1:0]   mem_write_addr,
  output logic [WEIGHT_WIDTH-1:0] mem_write_data,
  output logic [31:0]             stat_inf_cnt,
  output logic [31:0]             stat_lrn_cnt,
  output logic [31:0]             stat_stall_cnt
);

  localparam int WW = WEIGHT_WIDTH;
  localparam int DW = DELTA_WIDTH;
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_LIMIT = SW'(MAX_STALL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WAIT = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DW-1:0]           delta_q;
  logic [WW-1:0]           wdata_q;
  logic [SW-1:0]           stall_q;
  logic                    inf_owner_q;

  logic                    lrn_read;
  logic                    inf_lost;
  logic                    hazard;
  logic [WW:0]             sum;
  logic [WW-1:0]           sat_sum;

  // One guard bit is enough for the add as long as the delta is no wider than
  // the weight; overflow shows up as the two top bits disagreeing.
  always_comb begin
    sum = {mem_read_data[WW-1], mem_read_data} + {{(WW + 1 - DW){delta_q[DW-1]}}, delta_q};
    if (sum[WW] != sum[WW-1]) begin
      sat_sum = sum[WW] ? {1'b1, {(WW - 1){1'b0}}} : {1'b0, {(WW - 1){1'b1}}};
    end else begin
      sat_sum = sum[WW-1:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    lrn_read       = 1'b0;
    inf_lost       = 1'b0;
    hazard         = 1'b0;
    inf_gnt        = 1'b0;
    inf_rdata      = '0;
    inf_rvalid     = 1'b0;
    lrn_done       = 1'b0;
    host_ready     = 1'b0;
    mem_read_en    = 1'b0;
    mem_read_addr  = '0;
    mem_write_en   = 1'b0;
    mem_write_addr = '0;
    mem_write_data = '0;

    if (rst_n) begin
      case (state_q)
        S_IDLE: if (lrn_req) state_d = S_RD;
        S_RD: begin
          // Inference wins unless learning has already lost MAX_STALL times.
          lrn_read = !inf_req || (stall_q == STALL_LIMIT);
          inf_lost = !lrn_read;
          if (lrn_read) state_d = S_WAIT;
        end
        S_WAIT: if (mem_read_valid) state_d = S_WR;
        S_WR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      inf_gnt       = inf_req & ~lrn_read;
      mem_read_en   = inf_gnt | lrn_read;
      mem_read_addr = lrn_read ? addr_q : inf_addr;
      inf_rvalid    = mem_read_valid & inf_owner_q;
      inf_rdata     = mem_read_data;

      // A host write to the RMW address between its read and its write-back
      // would be silently overwritten, so it is held off.
      hazard     = ((state_q == S_RD) || (state_q == S_WAIT)) && (host_addr == addr_q);
      host_ready = host_wr_en && (state_q != S_WR) && !hazard;

      if (state_q == S_WR) begin
        mem_write_en   = 1'b1;
        mem_write_addr = addr_q;
        mem_write_data = wdata_q;
        lrn_done       = 1'b1;
      end else if (host_ready) begin
        mem_write_en   = 1'b1;
        mem_write_addr = host_addr;
        mem_write_data = host_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      delta_q     <= '0;
      wdata_q     <= '0;
      stall_q     <= '0;
      inf_owner_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inf_owner_q <= inf_gnt;
      if ((state_q == S_IDLE) && lrn_req) begin
        addr_q  <= lrn_addr;
        delta_q <= lrn_delta;
      end
      if (lrn_read) begin
        stall_q <= '0;
      end else if (inf_lost) begin
        stall_q <= stall_q + SW'(1);
      end
      if ((state_q == S_WAIT) && mem_read_valid) begin
        wdata_q <= sat_sum;
      end
    end
  end

`ifdef WARB_STATS_EN
  logic [31:0] inf_cnt_q, lrn_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inf_cnt_q   <= '0;
      lrn_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (inf_gnt)  inf_cnt_q   <= inf_cnt_q + 32'd1;
      if (lrn_done) lrn_cnt_q   <= lrn_cnt_q + 32'd1;
      if (inf_lost) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_inf_cnt   = rst_n ? inf_cnt_q   : '0;
  assign stat_lrn_cnt   = rst_n ? lrn_cnt_q   : '0;
  assign stat_stall_cnt = rst_n ? stall_cnt_q : '0;
`else
  assign stat_inf_cnt   = '0;
  assign stat_lrn_cnt   = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_weight_access_arbiter.sv
module tb_weight_access_arbiter;

  localparam int NW = 4096;
  localparam int WW = 9;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inf_req;
  logic [AW-1:0] inf_addr;
  logic          inf_gnt;
  logic [WW-1:0] inf_rdata;
  logic          inf_rvalid;
  logic          lrn_req;
  logic [AW-1:0] lrn_addr;
  logic [DW-1:0] lrn_delta;
  logic          lrn_done;
  logic          host_wr_en;
  logic [AW-1:0] host_addr;
  logic [WW-1:0] host_data;
  logic          host_ready;
  logic          mem_read_en;
  logic [AW-1:0] mem_read_addr;
  logic [WW-1:0] mem_read_data;
  logic          mem_read_valid;
  logic          mem_write_en;
  logic [AW-1:0] mem_write_addr;
  logic [WW-1:0] mem_write_data;
  logic [31:0]   stat_inf_cnt, stat_lrn_cnt, stat_stall_cnt;

  weight_access_arbiter #(
    .NUM_WEIGHTS(NW), .WEIGHT_WIDTH(WW), .ADDR_WIDTH(AW),
    .DELTA_WIDTH(DW), .MAX_STALL(MS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .inf_req(inf_req), .inf_addr(inf_addr), .inf_gnt(inf_gnt),
    .inf_rdata(inf_rdata), .inf_rvalid(inf_rvalid),
    .lrn_req(lrn_req), .lrn_addr(lrn_addr), .lrn_delta(lrn_delta), .lrn_done(lrn_done),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_data(host_data), .host_ready(host_ready),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .stat_inf_cnt(stat_inf_cnt), .stat_lrn_cnt(stat_lrn_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  // Weight memory: one-cycle read latency, read returns the pre-write value.
  logic [WW-1:0] bmem [0:NW-1];
  logic [WW-1:0] mem_rdata_q  = '0;
  logic          mem_rvalid_q = 1'b0;
  always @(posedge clk) begin
    if (mem_read_en) mem_rdata_q <= bmem[mem_read_addr];
    mem_rvalid_q <= mem_read_en;
    if (mem_write_en) bmem[mem_write_addr] <= mem_write_data;
  end
  assign mem_read_data  = mem_rdata_q;
  assign mem_read_valid = mem_rvalid_q;

  int n_cmp, n_err;

  // Reference model: weight contents plus the progress of the one RMW in flight.
  int ref_mem [0:15];
  bit m_active, m_rd_done, m_prev_inf;
  int m_a, m_d, m_loss, m_rcyc, m_new, m_prev_val, cyc;
  int s_inf, s_lrn, s_stall;
  logic obs_done;
  int gnt_seen;

  function automatic int sat(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  function automatic int pre(input int i);
    if (i == 5) return 10;
    if (i == 7) return 250;
    if (i == 8) return -250;
    return i * 7 - 40;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, check at negedge, advance model.
  task automatic step(input bit rn, input bit ir, input int ia, input bit lr, input int la,
                      input int ld, input bit hw, input int ha, input int hd);
    bit g, rd, wr, lost, hr;
    int wa, wd;
    rst_n = rn; inf_req = ir; inf_addr = AW'(ia);
    lrn_req = lr; lrn_addr = AW'(la); lrn_delta = DW'(ld);
    host_wr_en = hw; host_addr = AW'(ha); host_data = WW'(hd);
    g = 0; rd = 0; wr = 0; lost = 0; hr = 0; wa = 0; wd = 0;
    if (rn) begin
      wr = m_active && m_rd_done && (cyc == m_rcyc + 2);
      if (m_active && !m_rd_done) begin
        rd   = !ir || (m_loss == MS);
        lost = !rd;
      end
      g  = ir && !rd;
      hr = hw && !wr && !(m_active && ha == m_a);
      if (wr) begin wa = m_a; wd = m_new; end
      else if (hr) begin wa = ha; wd = hd; end
    end
    @(negedge clk);
    chk("inf_gnt", inf_gnt, g);
    chk("mem_read_en", mem_read_en, g || rd);
    if (g || rd) chk("mem_read_addr", mem_read_addr, rd ? m_a : ia);
    chk("host_ready", host_ready, hr);
    chk("lrn_done", lrn_done, wr);
    chk("mem_write_en", mem_write_en, wr || hr);
    if (wr || hr) begin
      chk("mem_write_addr", mem_write_addr, wa);
      chk("mem_write_data", $signed(mem_write_data), wd);
    end
    chk("inf_rvalid", inf_rvalid, rn && m_prev_inf);
    if (rn && m_prev_inf) chk("inf_rdata", $signed(inf_rdata), m_prev_val);
    if (!rn) chk("rst_outs", |{mem_read_addr, mem_write_addr, mem_write_data, inf_rdata}, 0);
`ifdef WARB_STATS_EN
    chk("stat_inf", stat_inf_cnt, rn ? s_inf : 0);
    chk("stat_lrn", stat_lrn_cnt, rn ? s_lrn : 0);
    chk("stat_stall", stat_stall_cnt, rn ? s_stall : 0);
`else
    chk("stat_zero", stat_inf_cnt | stat_lrn_cnt | stat_stall_cnt, 0);
`endif
    obs_done = lrn_done;
    if (inf_gnt === 1'b1) gnt_seen++;

    if (!rn) begin
      m_active = 0; m_rd_done = 0; m_prev_inf = 0;
      s_inf = 0; s_lrn = 0; s_stall = 0;
    end else begin
      m_prev_inf = g;
      if (g) m_prev_val = ref_mem[ia];
      if (rd) begin m_rd_done = 1; m_rcyc = cyc; m_new = sat(ref_mem[m_a] + m_d); end
      if (lost) m_loss++;
      s_inf += int'(g); s_lrn += int'(wr); s_stall += int'(lost);
      if (wr || hr) ref_mem[wa] = wd;
      if (wr) m_active = 0;
      else if (!m_active && lr) begin
        m_active = 1; m_rd_done = 0; m_a = la; m_d = ld; m_loss = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rmw(input int a, input int d, input bit ir, input int ia, output int n);
    n = 0;
    obs_done = 1'b0;
    while (obs_done !== 1'b1 && n < 30) begin
      step(1, ir, ia, 1, a, d, 0, 0, 0);
      n++;
    end
    if (obs_done !== 1'b1) chk("rmw_timeout", obs_done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_cmp = 0; n_err = 0; cyc = 0; gnt_seen = 0;
    m_active = 0; m_rd_done = 0; m_prev_inf = 0;
    m_a = 0; m_d = 0; m_loss = 0; m_rcyc = 0; m_new = 0; m_prev_val = 0;
    s_inf = 0; s_lrn = 0; s_stall = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 0;
    rst_n = 0; inf_req = 0; inf_addr = '0; lrn_req = 0; lrn_addr = '0; lrn_delta = '0;
    host_wr_en = 0; host_addr = '0; host_data = '0;
    @(posedge clk);
    #1;

    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 0, 1, i, pre(i));

    // Basic RMW: 10 + 3, write-back three cycles after acceptance.
    rmw(5, 3, 0, 0, n);
    chk("t1_len", n, 4);
    chk("t1_mem", $signed(bmem[5]), 13);

    // Saturation at both ends.
    rmw(7, 20, 0, 0, n);
    chk("t2_pos_sat", $signed(bmem[7]), 255);
    rmw(8, -20, 0, 0, n);
    chk("t2_neg_sat", $signed(bmem[8]), -256);

    // Inference held high: four losses, then forced learning read.
    gnt_seen = 0;
    rmw(1, 5, 1, 4, n);
    chk("t3_len", n, 8);
    chk("t3_gnts", gnt_seen, 7);
    chk("t3_mem", $signed(bmem[1]), -28);

    // Host hazard on the RMW address; other address goes straight through.
    for (int k = 0; k < 5; k++)
      step(1, 0, 0, k < 4, 9, 4, k >= 1, (k == 1) ? 3 : 9, (k == 1) ? 21 : 77);
    chk("t4_mem9", $signed(bmem[9]), 77);
    chk("t4_mem3", $signed(bmem[3]), 21);

    // Host write colliding with the write-back cycle.
    for (int k = 0; k < 5; k++)
      step(1, 0, 0, k < 4, 11, 1, k >= 3, 12, 33);
    chk("t5_mem11", $signed(bmem[11]), 38);
    chk("t5_mem12", $signed(bmem[12]), 33);

    // Reset while the RMW waits for read data: nothing is written.
    step(1, 0, 0, 1, 2, 9, 0, 0, 0);
    step(1, 0, 0, 1, 2, 9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_mem2", $signed(bmem[2]), -26);

    // Randomized mixed traffic on a small address window.
    for (int i = 0; i < 2000; i++) begin
      bit lr;
      lr = m_active ? 1'b1 : ($urandom_range(2, 0) == 0);
      step(1, $urandom_range(3, 0) != 0, $urandom_range(15, 0),
           lr, $urandom_range(15, 0), int'($urandom_range(255, 0)) - 128,
           $urandom_range(1, 0) == 1, $urandom_range(15, 0),
           int'($urandom_range(511, 0)) - 256);
    end
    for (int i = 0; i < 20 && m_active; i++) step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) chk("final_mem", $signed(bmem[i]), ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
